// File: rtl/obi_mem_port_arbiter.sv
// Shares one OBI memory port between the instruction and data interfaces,
// tracking outstanding IDs so in-order responses return to their owner.
module obi_mem_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter bit DATA_PRIO       = 1'b0,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          instr_req_i,
  input  logic [31:0]   instr_addr_i,
  output logic          instr_gnt_o,
  output logic          instr_rvalid_o,
  output logic [31:0]   instr_rdata_o,
  input  logic          data_req_i,
  input  logic          data_we_i,
  input  logic [3:0]    data_be_i,
  input  logic [31:0]   data_addr_i,
  input  logic [31:0]   data_wdata_i,
  output logic          data_gnt_o,
  output logic          data_rvalid_o,
  output logic [31:0]   data_rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [3:0]    mem_be_o,
  output logic [31:0]   mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [31:0]   mem_rdata_i,
  output logic [CW-1:0] outstanding_o,
  output logic          err_o
);

  logic [CW-1:0]              cnt_q, cnt_d;
  logic [MAX_OUTSTANDING-1:0] id_q, id_d;
  logic lock_q, lock_d;
  logic owner_q, owner_d;
  logic rr_q, rr_d;
  logic err_q, err_d;
  logic full, empty;
  logic sel, sel_req, req, accept, pop;

  assign full  = cnt_q == CW'(MAX_OUTSTANDING);
  assign empty = cnt_q == '0;

  // sel: 0 = instr, 1 = data; rr_q set means data is favoured
  always_comb begin
    sel = data_req_i;
    priority case (1'b1)
      lock_q:                    sel = owner_q;
      instr_req_i && data_req_i: sel = DATA_PRIO | rr_q;
      default:                   sel = data_req_i;
    endcase
  end

  assign sel_req = sel ? data_req_i : instr_req_i;
  assign req     = rst_ni & ~full & sel_req;
  assign accept  = req & mem_gnt_i;
  assign pop     = mem_rvalid_i & ~empty;

  assign mem_req_o   = req;
  assign mem_we_o    = sel & data_we_i;
  assign mem_be_o    = sel ? data_be_i : 4'hF;
  assign mem_addr_o  = sel ? data_addr_i : instr_addr_i;
  assign mem_wdata_o = sel ? data_wdata_i : 32'h0;

  assign instr_gnt_o    = accept & ~sel;
  assign data_gnt_o     = accept & sel;
  assign instr_rvalid_o = rst_ni & pop & ~id_q[0];
  assign data_rvalid_o  = rst_ni & pop & id_q[0];
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign outstanding_o  = cnt_q;
  assign err_o          = err_q;

  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    err_d   = err_q | (mem_rvalid_i & empty);
    if (accept) begin
      lock_d = 1'b0;
      rr_d   = ~sel;
    end else if (req) begin
      lock_d  = 1'b1;
      owner_d = sel;
    end else if (lock_q && !sel_req) begin
      lock_d = 1'b0;
    end
  end

  // ID FIFO: head at bit 0, pop shifts down, push lands after the survivors
  always_comb begin
    id_d  = id_q;
    cnt_d = cnt_q;
    if (pop) begin
      id_d  = id_q >> 1;
      cnt_d = cnt_q - CW'(1);
    end
    if (accept) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (CW'(i) == cnt_d) id_d[i] = sel;
      end
      cnt_d = cnt_d + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      id_q    <= '0;
      lock_q  <= 1'b0;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      lock_q  <= lock_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_obi_mem_port_arbiter.sv
// Directed bench for obi_mem_port_arbiter: round-robin and data-priority
// instances share stimulus; outputs sampled on the falling edge.
module tb_obi_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ir, dr, dwe, gnt, rv;
  logic [3:0]  dbe;
  logic [31:0] iaddr, daddr, dwdata, rdata;

  logic        ig, irv, dg, drv, mreq, mwe, err;
  logic [31:0] ird, drd, maddr, mwdata;
  logic [3:0]  mbe;
  logic [1:0]  out;

  logic        p_ig, p_irv, p_dg, p_drv, p_mreq, p_mwe, p_err;
  logic [31:0] p_ird, p_drd, p_maddr, p_mwdata;
  logic [3:0]  p_mbe;
  logic [1:0]  p_out;

  int checks = 0;
  int failures = 0;

  obi_mem_port_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIO(1'b0)) u0 (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(ir), .instr_addr_i(iaddr), .instr_gnt_o(ig),
    .instr_rvalid_o(irv), .instr_rdata_o(ird),
    .data_req_i(dr), .data_we_i(dwe), .data_be_i(dbe),
    .data_addr_i(daddr), .data_wdata_i(dwdata), .data_gnt_o(dg),
    .data_rvalid_o(drv), .data_rdata_o(drd),
    .mem_req_o(mreq), .mem_we_o(mwe), .mem_be_o(mbe),
    .mem_addr_o(maddr), .mem_wdata_o(mwdata), .mem_gnt_i(gnt),
    .mem_rvalid_i(rv), .mem_rdata_i(rdata),
    .outstanding_o(out), .err_o(err)
  );

  obi_mem_port_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIO(1'b1)) u1 (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(ir), .instr_addr_i(iaddr), .instr_gnt_o(p_ig),
    .instr_rvalid_o(p_irv), .instr_rdata_o(p_ird),
    .data_req_i(dr), .data_we_i(dwe), .data_be_i(dbe),
    .data_addr_i(daddr), .data_wdata_i(dwdata), .data_gnt_o(p_dg),
    .data_rvalid_o(p_drv), .data_rdata_o(p_drd),
    .mem_req_o(p_mreq), .mem_we_o(p_mwe), .mem_be_o(p_mbe),
    .mem_addr_o(p_maddr), .mem_wdata_o(p_mwdata), .mem_gnt_i(gnt),
    .mem_rvalid_i(rv), .mem_rdata_i(rdata),
    .outstanding_o(p_out), .err_o(p_err)
  );

  typedef struct {
    logic ir, dr, we, gnt, rv;
    logic [31:0] rdata;
    logic eig, edg, ereq, eseld, eirv, edrv;
    logic [1:0] eout;
    logic eerr;
  } vec_t;

  vec_t tv[18];

  function automatic vec_t mk(
    logic i_r, logic d_r, logic w, logic g, logic r, logic [31:0] rd,
    logic e_ig, logic e_dg, logic e_rq, logic e_sd,
    logic e_irv, logic e_drv, logic [1:0] e_out, logic e_err);
    vec_t v;
    v.ir = i_r; v.dr = d_r; v.we = w; v.gnt = g; v.rv = r; v.rdata = rd;
    v.eig = e_ig; v.edg = e_dg; v.ereq = e_rq; v.eseld = e_sd;
    v.eirv = e_irv; v.edrv = e_drv; v.eout = e_out; v.eerr = e_err;
    return v;
  endfunction

  function automatic logic [140:0] act0();
    return {ig, dg, mreq, mwe, mbe, maddr, mwdata,
            irv, drv, ird, drd, out, err};
  endfunction

  function automatic logic [140:0] act1();
    return {p_ig, p_dg, p_mreq, p_mwe, p_mbe, p_maddr, p_mwdata,
            p_irv, p_drv, p_ird, p_drd, p_out, p_err};
  endfunction

  function automatic logic [140:0] expv(vec_t v);
    return {v.eig, v.edg, v.ereq, v.eseld & v.we,
            v.eseld ? dbe : 4'hF,
            v.eseld ? daddr : iaddr,
            v.eseld ? dwdata : 32'h0,
            v.eirv, v.edrv, v.rdata, v.rdata, v.eout, v.eerr};
  endfunction

  task automatic chk(string nm, logic [159:0] a, logic [159:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, a, e);
    end
  endtask

  task automatic zero_in();
    ir = 0; dr = 0; dwe = 0; gnt = 0; rv = 0; rdata = 32'h0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(string nm);
    rst_n = 1'b0;
    ir = 1; dr = 1; gnt = 1; rv = 1;
    @(negedge clk);
    chk({nm, "_forced"},
        160'({mreq, ig, dg, irv, drv, out, err, p_mreq, p_ig, p_dg}),
        160'(0));
    next_cyc();
    zero_in();
    rst_n = 1'b1;
  endtask

  initial begin
    iaddr = 32'h80; daddr = 32'h200; dbe = 4'h3; dwdata = 32'hDEADBEEF;
    zero_in();
    repeat (2) @(posedge clk);
    #1;
    do_reset("rst0");

    tv[0]  = mk(1,0,0,1,0,32'h0,        1,0,1,0, 0,0,2'd0,0);
    tv[1]  = mk(0,0,0,0,1,32'h00150513, 0,0,0,0, 1,0,2'd1,0);
    tv[2]  = mk(1,0,0,1,0,32'h0,        1,0,1,0, 0,0,2'd0,0);
    tv[3]  = mk(1,0,0,1,0,32'h0,        1,0,1,0, 0,0,2'd1,0);
    tv[4]  = mk(1,0,0,1,0,32'h0,        0,0,0,0, 0,0,2'd2,0);
    tv[5]  = mk(1,0,0,1,1,32'h11111111, 0,0,0,0, 1,0,2'd2,0);
    tv[6]  = mk(1,0,0,1,0,32'h0,        1,0,1,0, 0,0,2'd1,0);
    tv[7]  = mk(0,0,0,0,1,32'hAAAA0001, 0,0,0,0, 1,0,2'd2,0);
    tv[8]  = mk(0,0,0,0,1,32'h22222222, 0,0,0,0, 1,0,2'd1,0);
    tv[9]  = mk(1,0,0,1,0,32'h0,        1,0,1,0, 0,0,2'd0,0);
    tv[10] = mk(0,1,0,1,0,32'h0,        0,1,1,1, 0,0,2'd1,0);
    tv[11] = mk(0,0,0,0,1,32'hAAAA0001, 0,0,0,0, 1,0,2'd2,0);
    tv[12] = mk(0,0,0,0,1,32'hBBBB0002, 0,0,0,0, 0,1,2'd1,0);
    tv[13] = mk(0,0,0,0,1,32'h12345678, 0,0,0,0, 0,0,2'd0,0);
    tv[14] = mk(0,0,0,0,0,32'h0,        0,0,0,0, 0,0,2'd0,1);
    tv[15] = mk(0,1,1,1,0,32'h0,        0,1,1,1, 0,0,2'd0,1);
    tv[16] = mk(1,0,0,1,1,32'hCCCC0003, 1,0,1,0, 0,1,2'd1,1);
    tv[17] = mk(0,0,0,0,1,32'hDDDD0004, 0,0,0,0, 1,0,2'd1,1);

    for (int i = 0; i < 18; i++) begin
      ir = tv[i].ir; dr = tv[i].dr; dwe = tv[i].we;
      gnt = tv[i].gnt; rv = tv[i].rv; rdata = tv[i].rdata;
      @(negedge clk);
      chk($sformatf("vec%0d_rr", i), 160'(act0()), 160'(expv(tv[i])));
      chk($sformatf("vec%0d_dp", i), 160'(act1()), 160'(expv(tv[i])));
      next_cyc();
    end

    // reset with one outstanding and a sticky error pending
    zero_in();
    ir = 1; gnt = 1;
    @(negedge clk);
    chk("mid_acc", 160'({ig, mreq}), 160'(2'b11));
    next_cyc();
    zero_in();
    @(negedge clk);
    chk("mid_pre", 160'({out, err}), 160'({2'd1, 1'b1}));
    next_cyc();
    do_reset("mid");
    @(negedge clk);
    chk("mid_post", 160'({out, err, mreq}), 160'(0));
    next_cyc();
    rv = 1;
    @(negedge clk);
    chk("late_rv", 160'({irv, drv, err}), 160'(0));
    next_cyc();
    rv = 0;
    @(negedge clk);
    chk("late_err", 160'({err, out}), 160'({1'b1, 2'd0}));
    next_cyc();

    // contention: round-robin vs data priority
    do_reset("rr");
    ir = 1; dr = 1; gnt = 1;
    for (int c = 0; c < 4; c++) begin
      rv = (c != 0);
      @(negedge clk);
      chk($sformatf("rr_c%0d", c), 160'({ig, dg}),
          160'((c % 2 == 0) ? 2'b10 : 2'b01));
      chk($sformatf("dp_c%0d", c), 160'({p_ig, p_dg}), 160'(2'b01));
      next_cyc();
    end

    // lock holds the stalled fetch against a later data request
    do_reset("lock");
    iaddr = 32'h100;
    for (int c = 0; c < 5; c++) begin
      ir = (c < 4);
      dr = (c >= 1);
      gnt = (c >= 3);
      @(negedge clk);
      if (c < 4) begin
        chk($sformatf("lock_c%0d", c),
            160'({maddr, ig, dg, mreq}),
            160'({32'h100, (c == 3), 1'b0, 1'b1}));
        chk($sformatf("lockdp_c%0d", c),
            160'({p_maddr, p_ig, p_dg}),
            160'({32'h100, (c == 3), 1'b0}));
      end else begin
        chk("lock_c4", 160'({maddr, ig, dg}),
            160'({32'h200, 1'b0, 1'b1}));
      end
      next_cyc();
    end
    zero_in();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
